// File: rtl/abs_diff_arbiter_if.sv
// Request/response bus for the shared |a-b| stage.
//   i_req_valid/o_req_ready : per-requester valid/ready handshake
//   i_req_data1/i_req_data2 : packed operands a and b, requester k at [k*WIDTH +: WIDTH]
//   o_rsp_valid/i_rsp_ready : result handshake
//   o_rsp_data/o_rsp_id     : |a-b| and the index of the requester that produced it
// master: requesters plus downstream consumer; slave: the arbiter.
interface abs_diff_arbiter_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) ();
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [NUM_REQ*WIDTH-1:0] i_req_data1;
  logic [NUM_REQ*WIDTH-1:0] i_req_data2;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [WIDTH-1:0]         o_rsp_data;
  logic [ID_W-1:0]          o_rsp_id;

  modport master (
    output i_req_valid, i_req_data1, i_req_data2, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_id
  );

  modport slave (
    input  i_req_valid, i_req_data1, i_req_data2, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_id
  );
endinterface

// File: rtl/abs_diff_arbiter.sv
// Round-robin shared unsigned absolute-difference unit.
//   sys_clk   : rising-edge clock
//   sys_rst_n : asynchronous active-low reset, discards in-flight work
//   i_en      : arbitration enable; in-flight results still drain when low
//   bus       : request/response bus (slave side)
// Two-stage pipeline: operand register (a, b, id, v1) then output register.
module abs_diff_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    i_en,
  abs_diff_arbiter_if.slave       bus
);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               v1_q;

  logic               stall_c;
  logic               hs_c;
  logic [ID_W-1:0]    gnt_idx_c;
  logic [ID_W-1:0]    cand_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    ptr_nxt_c;
  logic [WIDTH-1:0]   a_sel_c;
  logic [WIDTH-1:0]   b_sel_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   absdiff_c;
  int unsigned        idx_c;

  assign stall_c = bus.o_rsp_valid & ~bus.i_rsp_ready;

  // Round-robin scan from ptr; grant is forced low while reset is asserted.
  always_comb begin : arb
    grant_c   = '0;
    gnt_idx_c = '0;
    hs_c      = 1'b0;
    idx_c     = 0;
    cand_c    = '0;
    if (sys_rst_n && i_en && !stall_c) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx_c = 32'(ptr_q) + i;
        if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
        cand_c = ID_W'(idx_c);
        if (!hs_c && bus.i_req_valid[cand_c]) begin
          hs_c      = 1'b1;
          gnt_idx_c = cand_c;
        end
      end
      grant_c[gnt_idx_c] = hs_c;
    end
  end

  assign bus.o_req_ready = grant_c;

  assign ptr_nxt_c = (32'(gnt_idx_c) == NUM_REQ - 1) ? '0 : gnt_idx_c + ID_W'(1);

  // Operand mux for the granted requester.
  always_comb begin : opsel
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(gnt_idx_c) == k) begin
        a_sel_c = bus.i_req_data1[k*WIDTH +: WIDTH];
        b_sel_c = bus.i_req_data2[k*WIDTH +: WIDTH];
      end
    end
  end

  // b - a via b + ~a + 1; carry set means b >= a, otherwise negate the result.
  assign sum_c     = {1'b0, b_q} + {1'b0, ~a_q} + (WIDTH+1)'(1);
  assign absdiff_c = sum_c[WIDTH] ? sum_c[WIDTH-1:0] : (~sum_c[WIDTH-1:0] + WIDTH'(1));

  // Stage 1: operand capture and round-robin pointer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      v1_q  <= 1'b0;
      ptr_q <= '0;
    end else if (!stall_c) begin
      if (hs_c) begin
        a_q   <= a_sel_c;
        b_q   <= b_sel_c;
        id_q  <= gnt_idx_c;
        v1_q  <= 1'b1;
        ptr_q <= ptr_nxt_c;
      end else begin
        v1_q  <= 1'b0;
      end
    end
  end

  // Stage 2: output register; data and id hold when no new result arrives.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_data  <= '0;
      bus.o_rsp_id    <= '0;
    end else if (!stall_c) begin
      bus.o_rsp_valid <= v1_q;
      if (v1_q) begin
        bus.o_rsp_data <= absdiff_c;
        bus.o_rsp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_abs_diff_arbiter.sv
// Directed self-checking bench for abs_diff_arbiter.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_abs_diff_arbiter;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic sys_clk;
  logic sys_rst_n;
  logic i_en;
  int   n_checks;
  int   n_fail;

  abs_diff_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  abs_diff_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (i_en),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Contention operands and their hand-computed differences.
  logic [15:0] ca [4];
  logic [15:0] cb [4];
  logic [15:0] cd [4];

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
    bus.i_req_data1[k*WIDTH +: WIDTH] = a;
    bus.i_req_data2[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    i_en = 1'b1;
    bus.i_rsp_ready = 1'b1;
    bus.i_req_valid = 4'b1111;
    bus.i_req_data1 = '0;
    bus.i_req_data2 = '0;
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.o_rsp_valid); end
    n_checks++; if (bus.o_rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", bus.o_rsp_data); end
    n_checks++; if (bus.o_rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", bus.o_rsp_id); end
    n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", bus.o_req_ready); end
    bus.i_req_valid = 4'b0000;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_single;
    set_req(2, 16'h0010, 16'h0003);
    bus.i_req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", bus.o_req_ready); end
    @(negedge sys_clk);
    bus.i_req_valid = 4'b0000;
    #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %0b want 0", bus.o_rsp_valid); end
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", bus.o_rsp_valid); end
    n_checks++; if (bus.o_rsp_data !== 16'h000D) begin n_fail++; $display("FAIL single_data got %h want 000d", bus.o_rsp_data); end
    n_checks++; if (bus.o_rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", bus.o_rsp_id); end
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_once got %0b want 0", bus.o_rsp_valid); end
  endtask

  task automatic test_boundary;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vd [4];
    va = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    vb = '{16'hFFFF, 16'h0000, 16'h8000, 16'h8000};
    vd = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      set_req(0, va[i], vb[i]);
      bus.i_req_valid = 4'b0001;
      #1;
      n_checks++; if (bus.o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL bnd%0d_grant got %b want 0001", i, bus.o_req_ready); end
      @(negedge sys_clk);
      bus.i_req_valid = 4'b0000;
      @(negedge sys_clk); #1;
      n_checks++; if (bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bnd%0d_valid got %0b want 1", i, bus.o_rsp_valid); end
      n_checks++; if (bus.o_rsp_data !== vd[i]) begin n_fail++; $display("FAIL bnd%0d_data got %h want %h", i, bus.o_rsp_data, vd[i]); end
      @(negedge sys_clk);
    end
  endtask

  // Leaves the bench on the falling edge after eight grants (index 8 in the sequence).
  task automatic test_contention;
    logic [3:0] exp_rdy;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ca = '{16'h0001, 16'h1234, 16'h0100, 16'h0000};
    cb = '{16'h0003, 16'h0034, 16'h0100, 16'h00FF};
    cd = '{16'h0002, 16'h1200, 16'h0000, 16'h00FF};
    for (int k = 0; k < 4; k++) set_req(k, ca[k], cb[k]);
    bus.i_req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      n_checks++; if (bus.o_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", c, bus.o_req_ready, exp_rdy); end
      if (c < 2) begin
        n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_fill%0d got %0b want 0", c, bus.o_rsp_valid); end
      end else begin
        n_checks++; if (bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid%0d got %0b want 1", c, bus.o_rsp_valid); end
        n_checks++; if (bus.o_rsp_id !== 2'((c - 2) % 4)) begin n_fail++; $display("FAIL rr_id%0d got %0d want %0d", c, bus.o_rsp_id, (c - 2) % 4); end
        n_checks++; if (bus.o_rsp_data !== cd[(c - 2) % 4]) begin n_fail++; $display("FAIL rr_data%0d got %h want %h", c, bus.o_rsp_data, cd[(c - 2) % 4]); end
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_backpressure;
    bus.i_rsp_ready = 1'b0;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_stall got %b want 0000", bus.o_req_ready); end
    for (int j = 0; j < 3; j++) begin
      @(negedge sys_clk); #1;
      n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0000", j, bus.o_req_ready); end
      n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd2 || bus.o_rsp_data !== cd[2])
        begin n_fail++; $display("FAIL bp_hold%0d got v=%0b id=%0d d=%h want v=1 id=2 d=%h", j, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, cd[2]); end
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_grant got %b want 0001", bus.o_req_ready); end
    @(negedge sys_clk);
    bus.i_req_valid = 4'b0000;
    #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd3 || bus.o_rsp_data !== cd[3])
      begin n_fail++; $display("FAIL bp_first got v=%0b id=%0d d=%h want v=1 id=3 d=%h", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, cd[3]); end
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd0 || bus.o_rsp_data !== cd[0])
      begin n_fail++; $display("FAIL bp_second got v=%0b id=%0d d=%h want v=1 id=0 d=%h", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, cd[0]); end
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", bus.o_rsp_valid); end
  endtask

  task automatic test_enable;
    i_en = 1'b0;
    bus.i_req_valid = 4'b1111;
    set_req(1, 16'h0050, 16'h0020);
    for (int j = 0; j < 3; j++) begin
      #1;
      n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_off_grant%0d got %b want 0000", j, bus.o_req_ready); end
      n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_rsp%0d got %0b want 0", j, bus.o_rsp_valid); end
      @(negedge sys_clk);
    end
    i_en = 1'b1;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0010) begin n_fail++; $display("FAIL en_on_grant got %b want 0010", bus.o_req_ready); end
    @(negedge sys_clk);
    i_en = 1'b0;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_fall_grant got %b want 0000", bus.o_req_ready); end
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd1 || bus.o_rsp_data !== 16'h0030)
      begin n_fail++; $display("FAIL en_inflight got v=%0b id=%0d d=%h want v=1 id=1 d=0030", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data); end
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL en_single got %0b want 0", bus.o_rsp_valid); end
    bus.i_req_valid = 4'b0000;
  endtask

  task automatic test_reset_midop;
    i_en = 1'b1;
    set_req(2, 16'h0009, 16'h0004);
    bus.i_req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_pre_grant got %b want 0100", bus.o_req_ready); end
    @(negedge sys_clk);
    bus.i_req_valid = 4'b0000;
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_data !== 16'h0 || bus.o_rsp_id !== 2'd0)
      begin n_fail++; $display("FAIL rst_mid_out got v=%0b id=%0d d=%h want all 0", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge sys_clk); #1;
      n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale%0d got %0b want 0", j, bus.o_rsp_valid); end
    end
    set_req(0, 16'h0100, 16'h0001);
    bus.i_req_valid = 4'b1111;
    #1;
    n_checks++; if (bus.o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_restart got %b want 0001", bus.o_req_ready); end
    @(negedge sys_clk);
    bus.i_req_valid = 4'b0000;
    @(negedge sys_clk); #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd0 || bus.o_rsp_data !== 16'h00FF)
      begin n_fail++; $display("FAIL rst_post got v=%0b id=%0d d=%h want v=1 id=0 d=00ff", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_boundary();
    test_contention();
    test_backpressure();
    test_enable();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
